// File: rtl/ara_sim_ctrl.sv
// Simulation-control block for Ara SoC test tops: drives the DUT reset, tracks a run-cycle
// budget and gathers exit codes from several sources. After a drain window it reports one
// sticky pass/fail/timeout verdict.
module ara_sim_ctrl #(
   parameter int unsigned NrChannels   = 1,
   parameter int unsigned ResetCycles  = 20,
   parameter int unsigned MaxRunCycles = 32'h3000000,
   parameter int unsigned DrainCycles  = 100,
   parameter int unsigned CntWidth     = 32,
   parameter int unsigned ExitWidth    = 32
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   output logic                            dut_rst_no,
   input  logic [NrChannels-1:0]           exit_valid_i,
   input  logic [NrChannels*ExitWidth-1:0] exit_code_i,
   input  logic [NrChannels-1:0]           hw_cnt_en_i,
   output logic [1:0]                      state_o,
   output logic [NrChannels-1:0]           exited_o,
   output logic [CntWidth-1:0]             cycle_cnt_o,
   output logic [CntWidth-1:0]             active_cnt_o,
   output logic [ExitWidth-1:0]            exit_code_o,
   output logic                            timeout_o,
   output logic                            done_o,
   output logic                            pass_o
);

   typedef enum logic [1:0] {
      StReset = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam logic [CntWidth-1:0] LpResetLast = CntWidth'(ResetCycles - 1);
   localparam logic [CntWidth-1:0] LpRunLast   = CntWidth'(MaxRunCycles - 1);
   localparam logic [CntWidth-1:0] LpDrainLast = CntWidth'(DrainCycles - 1);

   state_e                r_state;
   logic                  r_dut_rst_n;
   // Shared by RESET and DRAIN; RUN leaves it at 0 so DRAIN starts from 0.
   logic [CntWidth-1:0]   r_phase_cnt;
   logic [CntWidth-1:0]   r_cycle_cnt;
   logic [CntWidth-1:0]   r_active_cnt;
   logic [NrChannels-1:0] r_exited;
   logic [ExitWidth-1:0]  r_code [NrChannels];
   logic                  r_timeout;
   logic                  r_done;

   logic [NrChannels-1:0] w_new_exit;
   logic [NrChannels-1:0] w_exited_upd;
   logic                  w_all_exited;
   logic                  w_budget_hit;
   logic [ExitWidth-1:0]  w_exit_code;
   logic                  w_codes_zero;

   // Exit bookkeeping for the current RUN cycle, including strobes arriving this cycle.
   always_comb begin
      w_new_exit   = exit_valid_i & ~r_exited;
      w_exited_upd = r_exited | w_new_exit;
      w_all_exited = &w_exited_upd;
      w_budget_hit = (r_cycle_cnt == LpRunLast);
   end

   // Lowest-index nonzero latched code wins; scan downwards so lower indices overwrite.
   always_comb begin
      w_exit_code  = '0;
      w_codes_zero = 1'b1;
      for (int c = NrChannels - 1; c >= 0; c--) begin
         if (r_code[c] != '0) begin
            w_exit_code  = r_code[c];
            w_codes_zero = 1'b0;
         end
      end
   end

   // Controller FSM with all registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= StReset;
         r_dut_rst_n  <= 1'b0;
         r_phase_cnt  <= '0;
         r_cycle_cnt  <= '0;
         r_active_cnt <= '0;
         r_exited     <= '0;
         r_timeout    <= 1'b0;
         r_done       <= 1'b0;
         for (int c = 0; c < NrChannels; c++) begin
            r_code[c] <= '0;
         end
      end else begin
         case (r_state)
            StReset: begin
               if (r_phase_cnt == LpResetLast) begin
                  r_state     <= StRun;
                  r_dut_rst_n <= 1'b1;
                  r_phase_cnt <= '0;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            StRun: begin
               if (!(&r_cycle_cnt)) begin
                  r_cycle_cnt <= r_cycle_cnt + 1'b1;
               end
               if ((|hw_cnt_en_i) && !(&r_active_cnt)) begin
                  r_active_cnt <= r_active_cnt + 1'b1;
               end
               for (int c = 0; c < NrChannels; c++) begin
                  if (w_new_exit[c]) begin
                     r_code[c] <= exit_code_i[c*ExitWidth +: ExitWidth];
                  end
               end
               r_exited <= w_exited_upd;
               // A final exit in the budget's last cycle takes priority over the timeout.
               if (w_all_exited) begin
                  r_state <= StDrain;
               end else if (w_budget_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= StDrain;
               end
            end
            StDrain: begin
               if (r_phase_cnt == LpDrainLast) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            StDone: begin
               r_state <= StDone;
            end
            default: begin
               r_state <= StReset;
            end
         endcase
      end
   end

   assign dut_rst_no   = r_dut_rst_n;
   assign state_o      = r_state;
   assign exited_o     = r_exited;
   assign cycle_cnt_o  = r_cycle_cnt;
   assign active_cnt_o = r_active_cnt;
   assign exit_code_o  = w_exit_code;
   assign timeout_o    = r_timeout;
   assign done_o       = r_done;
   assign pass_o       = r_done & (&r_exited) & ~r_timeout & w_codes_zero;

endmodule

// File: tb/tb_ara_sim_ctrl.sv
// Scoreboard bench for ara_sim_ctrl: each scenario pushes its expected final verdict when
// stimulus is driven; the record is popped and compared once the DUT reaches DONE.
module tb_ara_sim_ctrl;

   localparam int unsigned NrCh = 2;
   localparam int unsigned ExW  = 32;
   localparam int unsigned CntW = 32;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              dut_rst_no;
   logic [NrCh-1:0]   exit_valid_i;
   logic [NrCh*ExW-1:0] exit_code_i;
   logic [NrCh-1:0]   hw_cnt_en_i;
   logic [1:0]        state_o;
   logic [NrCh-1:0]   exited_o;
   logic [CntW-1:0]   cycle_cnt_o;
   logic [CntW-1:0]   active_cnt_o;
   logic [ExW-1:0]    exit_code_o;
   logic              timeout_o;
   logic              done_o;
   logic              pass_o;

   typedef struct {
      string       tag;
      logic [31:0] cyc;
      logic [31:0] act;
      logic [31:0] code;
      logic        to;
      logic        pass;
      logic [1:0]  ex;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   ara_sim_ctrl #(
      .NrChannels  (NrCh),
      .ResetCycles (20),
      .MaxRunCycles(100),
      .DrainCycles (100),
      .CntWidth    (CntW),
      .ExitWidth   (ExW)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .dut_rst_no  (dut_rst_no),
      .exit_valid_i(exit_valid_i),
      .exit_code_i (exit_code_i),
      .hw_cnt_en_i (hw_cnt_en_i),
      .state_o     (state_o),
      .exited_o    (exited_o),
      .cycle_cnt_o (cycle_cnt_o),
      .active_cnt_o(active_cnt_o),
      .exit_code_o (exit_code_o),
      .timeout_o   (timeout_o),
      .done_o      (done_o),
      .pass_o      (pass_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic strobe(input int ch, input logic [31:0] code);
      exit_valid_i[ch]            = 1'b1;
      exit_code_i[ch*ExW +: ExW]  = code;
      tick();
      exit_valid_i                = '0;
      exit_code_i                 = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_state"},  64'(state_o), 64'(0));
      check_eq({tag, "_rstn"},   64'(dut_rst_no), 64'(0));
      check_eq({tag, "_exited"}, 64'(exited_o), 64'(0));
      check_eq({tag, "_cyc"},    64'(cycle_cnt_o), 64'(0));
      check_eq({tag, "_act"},    64'(active_cnt_o), 64'(0));
      check_eq({tag, "_code"},   64'(exit_code_o), 64'(0));
      check_eq({tag, "_to"},     64'(timeout_o), 64'(0));
      check_eq({tag, "_done"},   64'(done_o), 64'(0));
      check_eq({tag, "_pass"},   64'(pass_o), 64'(0));
   endtask

   // Reset, then walk the 20-cycle DUT reset window; leaves the DUT in RUN cycle 0.
   task automatic reset_seq(input bit full);
      rst_i        = 1'b1;
      exit_valid_i = '0;
      exit_code_i  = '0;
      hw_cnt_en_i  = '0;
      tick();
      tick();
      if (full) check_reset_vals("rst");
      rst_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (full) check_eq($sformatf("rstwin%0d", i), 64'(dut_rst_no), 64'(0));
         tick();
      end
      check_eq("run_entry_state", 64'(state_o), 64'(1));
      check_eq("run_entry_rstn",  64'(dut_rst_no), 64'(1));
      check_eq("run_entry_cyc",   64'(cycle_cnt_o), 64'(0));
   endtask

   // Wait (bounded) for DONE, then pop the scoreboard and compare the verdict.
   task automatic wait_done(input int drain_left);
      exp_t e;
      int   n = 0;
      while (!done_o && n < 400) begin
         tick();
         n++;
      end
      e = exp_q.pop_front();
      check_eq({e.tag, "_drain_len"}, 64'(n), 64'(drain_left));
      check_eq({e.tag, "_state"},  64'(state_o), 64'(3));
      check_eq({e.tag, "_cyc"},    64'(cycle_cnt_o), 64'(e.cyc));
      check_eq({e.tag, "_act"},    64'(active_cnt_o), 64'(e.act));
      check_eq({e.tag, "_code"},   64'(exit_code_o), 64'(e.code));
      check_eq({e.tag, "_to"},     64'(timeout_o), 64'(e.to));
      check_eq({e.tag, "_pass"},   64'(pass_o), 64'(e.pass));
      check_eq({e.tag, "_exited"}, 64'(exited_o), 64'(e.ex));
      adv(5);
      check_eq({e.tag, "_hold_done"},  64'(done_o), 64'(1));
      check_eq({e.tag, "_hold_state"}, 64'(state_o), 64'(3));
   endtask

   initial begin
      // Clean run: both channels exit with code 0.
      reset_seq(1'b1);
      adv(50);
      strobe(0, 32'd0);
      check_eq("a_exited0", 64'(exited_o), 64'(1));
      check_eq("a_state_run", 64'(state_o), 64'(1));
      adv(29);
      strobe(1, 32'd0);
      check_eq("a_drain_state", 64'(state_o), 64'(2));
      check_eq("a_drain_rstn", 64'(dut_rst_no), 64'(1));
      exp_q.push_back('{tag: "a", cyc: 81, act: 0, code: 0, to: 1'b0, pass: 1'b1, ex: 2'b11});
      wait_done(100);

      // Nonzero codes, first-wins, re-strobe during DRAIN ignored.
      reset_seq(1'b0);
      adv(10);
      strobe(1, 32'd5);
      adv(4);
      strobe(1, 32'd7);
      check_eq("b_code_first", 64'(exit_code_o), 64'(5));
      check_eq("b_exited1", 64'(exited_o), 64'(2));
      adv(4);
      strobe(0, 32'd3);
      check_eq("b_drain_state", 64'(state_o), 64'(2));
      check_eq("b_drain_cyc", 64'(cycle_cnt_o), 64'(21));
      adv(4);
      strobe(0, 32'd0);
      exp_q.push_back('{tag: "b", cyc: 21, act: 0, code: 3, to: 1'b0, pass: 1'b0, ex: 2'b11});
      wait_done(95);

      // Timeout with no exits.
      reset_seq(1'b0);
      adv(99);
      check_eq("c_last_run_state", 64'(state_o), 64'(1));
      check_eq("c_last_run_to", 64'(timeout_o), 64'(0));
      adv(1);
      check_eq("c_to_state", 64'(state_o), 64'(2));
      check_eq("c_to_set", 64'(timeout_o), 64'(1));
      exp_q.push_back('{tag: "c", cyc: 100, act: 0, code: 0, to: 1'b1, pass: 1'b0, ex: 2'b00});
      wait_done(100);

      // Active window 10..39, final exit on the budget's last cycle, hw_cnt ignored in DRAIN.
      reset_seq(1'b0);
      adv(10);
      hw_cnt_en_i = 2'b01;
      adv(30);
      hw_cnt_en_i = 2'b00;
      check_eq("d_active", 64'(active_cnt_o), 64'(30));
      adv(10);
      strobe(0, 32'd0);
      adv(48);
      strobe(1, 32'd0);
      check_eq("d_drain_state", 64'(state_o), 64'(2));
      check_eq("d_no_timeout", 64'(timeout_o), 64'(0));
      hw_cnt_en_i = 2'b10;
      exp_q.push_back('{tag: "d", cyc: 100, act: 30, code: 0, to: 1'b0, pass: 1'b1, ex: 2'b11});
      wait_done(100);
      hw_cnt_en_i = 2'b00;

      // Simultaneous exits, then reset asserted in DRAIN.
      reset_seq(1'b0);
      adv(5);
      exit_valid_i = 2'b11;
      exit_code_i  = {32'd0, 32'd9};
      tick();
      exit_valid_i = '0;
      exit_code_i  = '0;
      check_eq("e_drain_state", 64'(state_o), 64'(2));
      check_eq("e_code", 64'(exit_code_o), 64'(9));
      adv(10);
      rst_i = 1'b1;
      tick();
      check_reset_vals("e_midrst");
      rst_i = 1'b0;

      if (exp_q.size() != 0) check_eq("sb_leftover", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
